// File: rtl/fetch_pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types and constants for the fetch PC controller:
//             sequencer state encoding, advance-length codes, reset vector.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // AdvLen_i encodings
    localparam logic ADV_ONE = 1'b0;
    localparam logic ADV_TWO = 1'b1;

    // Default PC loaded at reset
    localparam logic [15:0] DEF_RST_VEC = 16'h0000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_pc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_if
//  Purpose  : Control/fetch bundle between the core control (master) and the
//             fetch PC controller (slave). Carries advance/redirect/halt
//             requests in, and icmem address/load-mode plus PC status out.
//             RetireCnt_o exists only when RETIRE_CNT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_if #(
    parameter int PCW = 16
);
    logic            Adv_i;
    logic            AdvLen_i;
    logic            Redirect_i;
    logic [PCW-1:0]  RedirectPc_i;
    logic            Halt_i;
    logic [PCW-1:0]  Addr_o;
    logic            ML_en_o;
    logic [PCW-1:0]  PcCurr_o;
    logic            InsValid_o;
    logic            Halted_o;
`ifdef RETIRE_CNT_EN
    logic [31:0]     RetireCnt_o;

    modport master (
        output Adv_i, AdvLen_i, Redirect_i, RedirectPc_i, Halt_i,
        input  Addr_o, ML_en_o, PcCurr_o, InsValid_o, Halted_o, RetireCnt_o
    );
    modport slave (
        input  Adv_i, AdvLen_i, Redirect_i, RedirectPc_i, Halt_i,
        output Addr_o, ML_en_o, PcCurr_o, InsValid_o, Halted_o, RetireCnt_o
    );
`else
    modport master (
        output Adv_i, AdvLen_i, Redirect_i, RedirectPc_i, Halt_i,
        input  Addr_o, ML_en_o, PcCurr_o, InsValid_o, Halted_o
    );
    modport slave (
        input  Adv_i, AdvLen_i, Redirect_i, RedirectPc_i, Halt_i,
        output Addr_o, ML_en_o, PcCurr_o, InsValid_o, Halted_o
    );
`endif
endinterface : fetch_if
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_ctrl
//  Purpose  : Program counter and fetch sequencer for the multi-cycle DLP
//             core. Drives the dual-port icmem address and load mode so the
//             icmem InsCurr/InsNext pair always tracks PcCurr/PcCurr+1
//             across reset, hold, 1/2-word advance and redirect; tracks halt.
//             Optional macro RETIRE_CNT_EN adds a 32-bit retire counter.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int             PCW     = 16,
    parameter logic [PCW-1:0] RST_VEC = PCW'(DEF_RST_VEC)
) (
    input  wire logic Clk_i,
    input  wire logic Rst_n_i,
    fetch_if.slave    bus
);

    fetch_state_e    state_q, state_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;
    logic [PCW-1:0]  fetch_addr;
    logic            fetch_ml_en;

    // Next-state, next-PC and icmem address/mode selection
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        halted_d    = halted_q;
        fetch_addr  = pc_q;
        fetch_ml_en = 1'b1;

        case (state_q)
            ST_LOAD: begin
                // First fill after reset; only a redirect can change the target
                state_d = ST_RUN;
                valid_d = 1'b1;
                if (bus.Redirect_i) begin
                    fetch_addr = bus.RedirectPc_i;
                    pc_d       = bus.RedirectPc_i;
                end
            end
            ST_RUN: begin
                if (bus.Redirect_i) begin
                    fetch_addr = bus.RedirectPc_i;
                    pc_d       = bus.RedirectPc_i;
                end else if (bus.Adv_i) begin
                    if (bus.Halt_i) begin
                        // Re-read the HALT word pair so icmem stays aligned
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else if (bus.AdvLen_i == ADV_ONE) begin
                        // Stream: InsNext shifts into InsCurr, fetch PC+2 behind it
                        fetch_addr  = pc_q + PCW'(2);
                        fetch_ml_en = 1'b0;
                        pc_d        = pc_q + PCW'(1);
                    end else begin
                        // Skip the immediate word: reload the pair at PC+2
                        fetch_addr = pc_q + PCW'(2);
                        pc_d       = pc_q + PCW'(2);
                    end
                end
            end
            ST_HALT: begin
                // Target the redirect address so the restart is aligned
                if (bus.Redirect_i) begin
                    fetch_addr = bus.RedirectPc_i;
                    pc_d       = bus.RedirectPc_i;
                    state_d    = ST_RUN;
                    halted_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Hold icmem on the reset vector while reset is asserted
        if (!Rst_n_i) begin
            fetch_addr  = RST_VEC;
            fetch_ml_en = 1'b1;
        end
    end

    // State, PC and status registers
    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            state_q  <= ST_LOAD;
            pc_q     <= RST_VEC;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign bus.Addr_o     = fetch_addr;
    assign bus.ML_en_o    = fetch_ml_en;
    assign bus.PcCurr_o   = pc_q;
    assign bus.InsValid_o = valid_q;
    assign bus.Halted_o   = halted_q;

`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;
    logic        retire_inc;

    // Retire in RUN only; a redirect cycle is accounted for elsewhere
    assign retire_inc = (state_q == ST_RUN) && bus.Adv_i && !bus.Redirect_i;

    // Free-running retire counter, wraps at 2^32
    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            retire_cnt_q <= 32'd0;
        end else if (retire_inc) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign bus.RetireCnt_o = retire_cnt_q;
`endif

endmodule : fetch_pc_ctrl
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_pc_ctrl
//  Purpose  : Directed, table-driven bench for fetch_pc_ctrl with a
//             behavioural dual-port icmem attached to its outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_pc_ctrl;

    logic Clk_i;
    logic Rst_n_i;

    fetch_if #(.PCW(16)) bus ();

    fetch_pc_ctrl #(.PCW(16), .RST_VEC(16'h0000)) dut (
        .Clk_i   (Clk_i),
        .Rst_n_i (Rst_n_i),
        .bus     (bus)
    );

    initial Clk_i = 1'b0;
    always #5 Clk_i = ~Clk_i;

    // Synthetic ROM contents: distinct word per address
    function automatic logic [15:0] rom(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // icmem model following the documented load/stream contract
    logic [15:0] ins_cur, ins_nxt;
    always @(posedge Clk_i) begin
        if (bus.ML_en_o) begin
            ins_cur <= rom(bus.Addr_o);
            ins_nxt <= rom(bus.Addr_o + 16'd1);
        end else begin
            ins_cur <= ins_nxt;
            ins_nxt <= rom(bus.Addr_o);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic        adv;
        logic        len;
        logic        redir;
        logic [15:0] rpc;
        logic        halt;
        logic [15:0] e_addr;
        logic        e_ml;
        logic [15:0] e_pc;
        logic        e_halted;
        int          e_cnt;
    } vec_t;

    vec_t v [19];

    task automatic drive(input logic adv, input logic len, input logic redir,
                         input logic [15:0] rpc, input logic halt);
        bus.Adv_i        = adv;
        bus.AdvLen_i     = len;
        bus.Redirect_i   = redir;
        bus.RedirectPc_i = rpc;
        bus.Halt_i       = halt;
    endtask

    task automatic check_aligned(input string tag, input logic [15:0] pc);
        chk({tag, ".InsCurr"}, ins_cur, rom(pc));
        chk({tag, ".InsNext"}, ins_nxt, rom(pc + 16'd1));
    endtask

    initial begin
        //        adv  len  red  rpc       hlt  addr      ml   pc        hlt cnt
        v[0]  = '{1'b1,1'b1,1'b0,16'h0000,1'b1,16'h0000,1'b1,16'h0000,1'b0,0}; // LOAD ignores adv/halt
        v[1]  = '{1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0002,1'b0,16'h0001,1'b0,1};
        v[2]  = '{1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0003,1'b0,16'h0002,1'b0,2};
        v[3]  = '{1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0004,1'b0,16'h0003,1'b0,3};
        v[4]  = '{1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0005,1'b0,16'h0004,1'b0,4};
        v[5]  = '{1'b1,1'b1,1'b0,16'h0000,1'b0,16'h0006,1'b1,16'h0006,1'b0,5}; // two-word
        v[6]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0006,1'b1,16'h0006,1'b0,5}; // hold x3
        v[7]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0006,1'b1,16'h0006,1'b0,5};
        v[8]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0006,1'b1,16'h0006,1'b0,5};
        v[9]  = '{1'b1,1'b0,1'b1,16'h0040,1'b0,16'h0040,1'b1,16'h0040,1'b0,5}; // redirect beats adv
        v[10] = '{1'b1,1'b0,1'b0,16'h0000,1'b1,16'h0040,1'b1,16'h0040,1'b1,6}; // halt retire
        v[11] = '{1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0040,1'b1,16'h0040,1'b1,6}; // halted: adv ignored
        v[12] = '{1'b1,1'b1,1'b0,16'h0000,1'b1,16'h0040,1'b1,16'h0040,1'b1,6};
        v[13] = '{1'b0,1'b0,1'b1,16'h0000,1'b0,16'h0000,1'b1,16'h0000,1'b0,6}; // leave halt
        v[14] = '{1'b0,1'b0,1'b1,16'hFFFF,1'b0,16'hFFFF,1'b1,16'hFFFF,1'b0,6};
        v[15] = '{1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0001,1'b0,16'h0000,1'b0,7}; // 1-word wrap
        v[16] = '{1'b0,1'b0,1'b1,16'hFFFF,1'b0,16'hFFFF,1'b1,16'hFFFF,1'b0,7};
        v[17] = '{1'b1,1'b1,1'b0,16'h0000,1'b0,16'h0001,1'b1,16'h0001,1'b0,8}; // 2-word wrap
        v[18] = '{1'b1,1'b0,1'b1,16'h0100,1'b1,16'h0100,1'b1,16'h0100,1'b0,8}; // redirect beats halt

        // Reset with a pending redirect: outputs must sit on the reset vector
        Rst_n_i = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
        #1;
        chk("rst.Addr",     bus.Addr_o,     16'h0000);
        chk("rst.ML_en",    bus.ML_en_o,    1'b1);
        chk("rst.PcCurr",   bus.PcCurr_o,   16'h0000);
        chk("rst.InsValid", bus.InsValid_o, 1'b0);
        chk("rst.Halted",   bus.Halted_o,   1'b0);
        repeat (2) @(posedge Clk_i);
        @(negedge Clk_i);
        Rst_n_i = 1'b1;
`ifdef RETIRE_CNT_EN
        #1 chk("rst.RetireCnt", bus.RetireCnt_o, 32'd0);
`endif

        // Table: apply mid-low phase, check comb outputs, then registered results
        for (int i = 0; i < 19; i++) begin
            drive(v[i].adv, v[i].len, v[i].redir, v[i].rpc, v[i].halt);
            #1;
            if (i == 0) chk("load.InsValid", bus.InsValid_o, 1'b0);
            chk($sformatf("v%0d.Addr", i),  bus.Addr_o,  v[i].e_addr);
            chk($sformatf("v%0d.ML_en", i), bus.ML_en_o, v[i].e_ml);
            @(posedge Clk_i);
            #1;
            chk($sformatf("v%0d.PcCurr", i),   bus.PcCurr_o,   v[i].e_pc);
            chk($sformatf("v%0d.InsValid", i), bus.InsValid_o, 1'b1);
            chk($sformatf("v%0d.Halted", i),   bus.Halted_o,   v[i].e_halted);
            check_aligned($sformatf("v%0d", i), v[i].e_pc);
`ifdef RETIRE_CNT_EN
            chk($sformatf("v%0d.RetireCnt", i), bus.RetireCnt_o, v[i].e_cnt);
`endif
            @(negedge Clk_i);
        end

        // Enter halt, then reset asynchronously mid-cycle with a redirect pending
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        @(posedge Clk_i);
        #1 chk("mid.Halted.pre", bus.Halted_o, 1'b1);
        @(negedge Clk_i);
        drive(1'b0, 1'b0, 1'b1, 16'h0077, 1'b0);
        #2 Rst_n_i = 1'b0;
        #1;
        chk("mid.PcCurr",   bus.PcCurr_o,   16'h0000);
        chk("mid.InsValid", bus.InsValid_o, 1'b0);
        chk("mid.Halted",   bus.Halted_o,   1'b0);
        chk("mid.Addr",     bus.Addr_o,     16'h0000);
        chk("mid.ML_en",    bus.ML_en_o,    1'b1);
`ifdef RETIRE_CNT_EN
        chk("mid.RetireCnt", bus.RetireCnt_o, 32'd0);
`endif
        @(posedge Clk_i);
        @(negedge Clk_i);
        Rst_n_i = 1'b1;

        // Redirect honoured in the LOAD cycle
        drive(1'b0, 1'b0, 1'b1, 16'h0020, 1'b0);
        #1;
        chk("loadrd.Addr",     bus.Addr_o,     16'h0020);
        chk("loadrd.ML_en",    bus.ML_en_o,    1'b1);
        chk("loadrd.InsValid", bus.InsValid_o, 1'b0);
        @(posedge Clk_i);
        #1;
        chk("loadrd.PcCurr",   bus.PcCurr_o,   16'h0020);
        chk("loadrd.InsValid", bus.InsValid_o, 1'b1);
        check_aligned("loadrd", 16'h0020);
        @(negedge Clk_i);

        // Streaming continues from the redirected PC
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        #1;
        chk("post.Addr",  bus.Addr_o,  16'h0022);
        chk("post.ML_en", bus.ML_en_o, 1'b0);
        @(posedge Clk_i);
        #1;
        chk("post.PcCurr", bus.PcCurr_o, 16'h0021);
        check_aligned("post", 16'h0021);
`ifdef RETIRE_CNT_EN
        chk("post.RetireCnt", bus.RetireCnt_o, 32'd1);
`endif
        @(negedge Clk_i);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_pc_ctrl
`default_nettype wire
